pipe_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. It generates stall and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers from three sources: load-use hazards, EX-stage branch mispredicts and LSU back-pressure. It runs a small FSM so that fetch bubbles after a redirect cover synchronous IMEM latency. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencing states: normal flow, post-redirect fetch bubbles, LSU wait.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // x0 is hardwired to zero, so a load into it can never create a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Remaining fetch bubbles after a redirect (up to 7).
  typedef logic [2:0] bub_t;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts i_inc cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls,
// mispredict redirects with trailing fetch bubbles, LSU back-pressure, and
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mispredict,
  input  logic             i_mem_busy,
  output logic             o_pc_stall,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_stall,
  output logic             o_redirect,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam bit   HAS_REDIR = (REDIRECT_BUBBLES > 0);
  localparam bub_t BUB_INIT  = bub_t'(REDIRECT_BUBBLES);

  state_e state_q, state_d;
  bub_t   bub_q, bub_d;
  logic   lu;

  // Load-use hazard: ID reads the register an in-flight EX load writes.
  assign lu = i_ex_valid && i_ex_is_load && (i_ex_rd != REG_X0) && i_id_valid &&
              ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
               (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  // State and bubble-counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  // Next state: busy freezes everything, a mispredict (re)arms the bubbles.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (i_mem_busy) begin
          state_d = ST_MEM_WAIT;
        end else if (i_ex_mispredict && HAS_REDIR) begin
          state_d = ST_REDIRECT;
          bub_d   = BUB_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (i_mem_busy) begin
          state_d = ST_REDIRECT;
        end else if (i_ex_mispredict) begin
          bub_d = BUB_INIT;
        end else if (bub_q <= bub_t'(1)) begin
          state_d = ST_RUN;
          bub_d   = '0;
        end else begin
          bub_d = bub_q - bub_t'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        bub_d   = '0;
      end
    endcase
  end

  // Control outputs; held at zero while reset is asserted.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_redirect     = 1'b0;
    if (i_reset) begin
      if (i_mem_busy) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
      end else if (i_ex_mispredict) begin
        o_redirect    = 1'b1;
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (state_q == ST_REDIRECT) begin
        // ID holds a squashed slot here, so lu is not considered.
        o_if_id_flush = 1'b1;
      end else if (lu) begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (o_pc_stall),
    .o_cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (o_redirect),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2, CNT_W=4).
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush,
  //                        id_ex_stall, id_ex_flush, ex_mem_stall, redirect}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MISP = 7'b0010101;
  localparam logic [6:0] C_BUB  = 7'b0010000;
  localparam logic [6:0] C_BUSY = 7'b1101010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, use_rs1, use_rs2, ex_valid, ex_is_load, mispredict, mem_busy;
  logic [4:0]    rs1, rs2, rd;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, redirect};

  // clock / reset block
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(CW)) dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_id_valid      (id_valid),
    .i_id_rs1        (rs1),
    .i_id_rs2        (rs2),
    .i_id_use_rs1    (use_rs1),
    .i_id_use_rs2    (use_rs2),
    .i_ex_valid      (ex_valid),
    .i_ex_is_load    (ex_is_load),
    .i_ex_rd         (rd),
    .i_ex_mispredict (mispredict),
    .i_mem_busy      (mem_busy),
    .o_pc_stall      (pc_stall),
    .o_if_id_stall   (if_id_stall),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_stall   (id_ex_stall),
    .o_id_ex_flush   (id_ex_flush),
    .o_ex_mem_stall  (ex_mem_stall),
    .o_redirect      (redirect),
    .o_stall_cnt     (stall_cnt),
    .o_flush_cnt     (flush_cnt)
  );

  // driver tasks
  task automatic set_idle();
    id_valid = 0; use_rs1 = 0; use_rs2 = 0; ex_valid = 0; ex_is_load = 0;
    mispredict = 0; mem_busy = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic set_load_use(input logic [4:0] r_rd, input logic [4:0] r1, input logic [4:0] r2,
                              input logic u1, input logic u2);
    ex_valid = 1; ex_is_load = 1; rd = r_rd; id_valid = 1;
    rs1 = r1; rs2 = r2; use_rs1 = u1; use_rs2 = u2;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    mispredict = 1; mem_busy = 0;
    tick();
    tick();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, C_NONE); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    checks++; if (flush_cnt !== 0) begin errors++; $display("FAIL reset_flush_cnt: got %0d exp 0", flush_cnt); end
    set_idle();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1: got %b exp %b", ctl, C_LU); end
    tick();
    set_idle();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_after: got %b exp %b", ctl, C_NONE); end
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL lu_stall_cnt: got %0d exp 1", stall_cnt); end
    // rd = x0 never hazards
    set_load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_rd0: got %b exp %b", ctl, C_NONE); end
    // matching rs1 but not read
    set_load_use(5'd5, 5'd5, 5'd7, 1'b0, 1'b1);
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_nouse: got %b exp %b", ctl, C_NONE); end
    // EX not a load
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    ex_is_load = 0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL lu_notload: got %b exp %b", ctl, C_NONE); end
    // rs2 path
    set_load_use(5'd9, 5'd3, 5'd9, 1'b1, 1'b1);
    #1;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2: got %b exp %b", ctl, C_LU); end
    tick();
    set_idle();
    #1;
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL lu_stall_cnt2: got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_mispredict();
    do_reset();
    mispredict = 1;
    #1;
    checks++; if (ctl !== C_MISP) begin errors++; $display("FAIL misp_c0: got %b exp %b", ctl, C_MISP); end
    tick();
    mispredict = 0;
    // a load-use in ID during the bubbles must be ignored
    set_load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL misp_c1: got %b exp %b", ctl, C_BUB); end
    checks++; if (flush_cnt !== 1) begin errors++; $display("FAIL misp_flush_cnt: got %0d exp 1", flush_cnt); end
    tick();
    set_idle();
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL misp_c2: got %b exp %b", ctl, C_BUB); end
    tick();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL misp_c3: got %b exp %b", ctl, C_NONE); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL misp_stall_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    mem_busy = 1; mispredict = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL busy_c%0d: got %b exp %b", i, ctl, C_BUSY); end
      tick();
    end
    mem_busy = 0;
    #1;
    checks++; if (ctl !== C_MISP) begin errors++; $display("FAIL busy_release: got %b exp %b", ctl, C_MISP); end
    checks++; if (stall_cnt !== 3) begin errors++; $display("FAIL busy_stall_cnt: got %0d exp 3", stall_cnt); end
    checks++; if (flush_cnt !== 0) begin errors++; $display("FAIL busy_flush_cnt0: got %0d exp 0", flush_cnt); end
    tick();
    mispredict = 0;
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL busy_bub1: got %b exp %b", ctl, C_BUB); end
    checks++; if (flush_cnt !== 1) begin errors++; $display("FAIL busy_flush_cnt1: got %0d exp 1", flush_cnt); end
    tick();
    tick();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL busy_done: got %b exp %b", ctl, C_NONE); end
  endtask

  task automatic test_busy_in_redirect();
    logic [6:0] exp_seq [0:5];
    int flushes;
    exp_seq[0] = C_MISP; exp_seq[1] = C_BUSY; exp_seq[2] = C_BUSY;
    exp_seq[3] = C_BUB;  exp_seq[4] = C_BUB;  exp_seq[5] = C_NONE;
    flushes = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      mispredict = (i == 0);
      mem_busy   = (i == 1 || i == 2);
      #1;
      if (if_id_flush === 1'b1) flushes++;
      checks++; if (ctl !== exp_seq[i]) begin errors++; $display("FAIL rbusy_c%0d: got %b exp %b", i, ctl, exp_seq[i]); end
      tick();
    end
    checks++; if (flushes !== 3) begin errors++; $display("FAIL rbusy_flushes: got %0d exp 3", flushes); end
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL rbusy_stall_cnt: got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mispredict = 1;
    #1;
    checks++; if (ctl !== C_MISP) begin errors++; $display("FAIL b2b_c0: got %b exp %b", ctl, C_MISP); end
    tick();
    #1;
    checks++; if (ctl !== C_MISP) begin errors++; $display("FAIL b2b_c1: got %b exp %b", ctl, C_MISP); end
    tick();
    mispredict = 0;
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL b2b_c2: got %b exp %b", ctl, C_BUB); end
    checks++; if (flush_cnt !== 2) begin errors++; $display("FAIL b2b_flush_cnt: got %0d exp 2", flush_cnt); end
    tick();
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL b2b_c3: got %b exp %b", ctl, C_BUB); end
    tick();
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL b2b_c4: got %b exp %b", ctl, C_NONE); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1;
    repeat (20) tick();
    mem_busy = 0;
    #1;
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall_cnt: got %0d exp 15", stall_cnt); end
    tick();
    #1;
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d exp 15", stall_cnt); end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    mispredict = 1;
    tick();
    mispredict = 0;
    #1;
    checks++; if (ctl !== C_BUB) begin errors++; $display("FAIL rmid_pre: got %b exp %b", ctl, C_BUB); end
    rst_n = 0;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rmid_in_reset: got %b exp %b", ctl, C_NONE); end
    tick();
    rst_n = 1;
    #1;
    checks++; if (ctl !== C_NONE) begin errors++; $display("FAIL rmid_after: got %b exp %b", ctl, C_NONE); end
    checks++; if (flush_cnt !== 0) begin errors++; $display("FAIL rmid_flush_cnt: got %0d exp 0", flush_cnt); end
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_busy();
    test_busy_in_redirect();
    test_back_to_back();
    test_saturation();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
